// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock-setting controller: FSM states, field
// geometry of the packed {hour, min, sec} time word and the sel codes.
package clock_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam int unsigned TIME_W   = 17;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned SEC_W    = 6;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;

  localparam int unsigned HOUR_LSB = 12;
  localparam int unsigned MIN_LSB  = 6;
  localparam int unsigned SEC_LSB  = 0;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  // Replace any out-of-range field of a captured time with zero.
  function automatic logic [TIME_W-1:0] sanitize_time(input logic [TIME_W-1:0] t);
    logic [HOUR_W-1:0] h;
    logic [MIN_W-1:0]  m;
    logic [SEC_W-1:0]  s;
    h = t[HOUR_LSB +: HOUR_W];
    m = t[MIN_LSB  +: MIN_W];
    s = t[SEC_LSB  +: SEC_W];
    if (h > HOUR_W'(HOUR_MAX)) h = '0;
    if (m > MIN_W'(MIN_MAX))   m = '0;
    if (s > SEC_W'(SEC_MAX))   s = '0;
    return {h, m, s};
  endfunction

endpackage

// File: rtl/time_field_step.sv
// Combinational +/-1 step of one time field, wrapping between 0 and MAX.
module time_field_step #(
  parameter int unsigned W   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic [W-1:0] i_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_val
);

  // Increment wraps MAX->0, decrement wraps 0->MAX; otherwise pass through.
  always_comb begin
    o_val = i_val;
    if (i_inc) begin
      o_val = (i_val == W'(MAX)) ? '0 : i_val + W'(1);
    end else if (i_dec) begin
      o_val = (i_val == '0) ? W'(MAX) : i_val - W'(1);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: stops the time-of-day counter, lets the user
// edit hour/min/sec with inc/dec keys, then loads the edited time back.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned TIME_BLINK = 10_000_000,
  parameter int unsigned TIME_OUT   = 200_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_mode,
  input  logic              key_inc,
  input  logic              key_dec,
  input  logic [TIME_W-1:0] cur_time,
  output logic              run_en,
  output logic              load,
  output logic [TIME_W-1:0] load_time,
  output logic [1:0]        sel,
  output logic              blink
);

  localparam int unsigned BLINK_W = $clog2(TIME_BLINK + 1);
  localparam int unsigned TO_W    = (TIME_OUT > 1) ? $clog2(TIME_OUT) : 1;

  state_t              r_state;
  state_t              w_next;
  logic [TIME_W-1:0]   r_edit;
  logic [TIME_W-1:0]   r_load_time;
  logic [TIME_W-1:0]   w_edit_step;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink;
  logic [TO_W-1:0]     r_to;
  logic                w_in_edit;
  logic                w_next_edit;
  logic                w_enter;
  logic                w_any_key;
  logic                w_inc;
  logic                w_dec;
  logic                w_timeout;
  logic [HOUR_W-1:0]   w_hour_n;
  logic [MIN_W-1:0]    w_min_n;
  logic [SEC_W-1:0]    w_sec_n;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next    = r_state;
    run_en    = 1'b0;
    load      = 1'b0;
    sel       = SEL_NONE;
    w_in_edit = 1'b0;
    w_any_key = key_mode | key_inc | key_dec;
    w_timeout = (r_to == TO_W'(TIME_OUT - 1)) && !w_any_key;
    case (r_state)
      ST_RUN: begin
        run_en = 1'b1;
        if (key_mode) w_next = ST_SET_H;
      end
      ST_SET_H: begin
        sel       = SEL_HOUR;
        w_in_edit = 1'b1;
        if (key_mode)       w_next = ST_SET_M;
        else if (w_timeout) w_next = ST_RUN;
      end
      ST_SET_M: begin
        sel       = SEL_MIN;
        w_in_edit = 1'b1;
        if (key_mode)       w_next = ST_SET_S;
        else if (w_timeout) w_next = ST_RUN;
      end
      ST_SET_S: begin
        sel       = SEL_SEC;
        w_in_edit = 1'b1;
        if (key_mode)       w_next = ST_COMMIT;
        else if (w_timeout) w_next = ST_RUN;
      end
      ST_COMMIT: begin
        // Gated by rst_n so a reset landing on COMMIT never shows a load.
        load   = rst_n;
        w_next = ST_RUN;
      end
      default: w_next = ST_RUN;
    endcase
    // Mode wins over inc/dec; inc together with dec cancels both.
    w_inc       = w_in_edit & key_inc & ~key_dec & ~key_mode;
    w_dec       = w_in_edit & key_dec & ~key_inc & ~key_mode;
    w_next_edit = (w_next == ST_SET_H) || (w_next == ST_SET_M) || (w_next == ST_SET_S);
    w_enter     = w_next_edit && (w_next != r_state);
  end

  time_field_step #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour_step (
    .i_val (r_edit[HOUR_LSB +: HOUR_W]),
    .i_inc (w_inc && (r_state == ST_SET_H)),
    .i_dec (w_dec && (r_state == ST_SET_H)),
    .o_val (w_hour_n)
  );

  time_field_step #(.W(MIN_W), .MAX(MIN_MAX)) u_min_step (
    .i_val (r_edit[MIN_LSB +: MIN_W]),
    .i_inc (w_inc && (r_state == ST_SET_M)),
    .i_dec (w_dec && (r_state == ST_SET_M)),
    .o_val (w_min_n)
  );

  time_field_step #(.W(SEC_W), .MAX(SEC_MAX)) u_sec_step (
    .i_val (r_edit[SEC_LSB +: SEC_W]),
    .i_inc (w_inc && (r_state == ST_SET_S)),
    .i_dec (w_dec && (r_state == ST_SET_S)),
    .o_val (w_sec_n)
  );

  assign w_edit_step = {w_hour_n, w_min_n, w_sec_n};
  assign load_time   = r_load_time;
  assign blink       = r_blink;

  // Edit register, committed time, timeout and blink timers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_edit      <= '0;
      r_load_time <= '0;
      r_to        <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else begin
      if ((r_state == ST_RUN) && key_mode) r_edit <= sanitize_time(cur_time);
      else if (w_inc || w_dec)             r_edit <= w_edit_step;

      // Latched on entry to COMMIT so it is valid throughout the load cycle.
      if (w_next == ST_COMMIT) r_load_time <= r_edit;

      if (!w_next_edit || w_enter || w_any_key) r_to <= '0;
      else                                      r_to <= r_to + TO_W'(1);

      if (!w_next_edit) begin
        r_blink_cnt <= '0;
        r_blink     <= 1'b1;
      end else if (w_enter || w_inc || w_dec) begin
        r_blink_cnt <= BLINK_W'(1);
        r_blink     <= 1'b1;
      end else if (r_blink_cnt == BLINK_W'(TIME_BLINK)) begin
        r_blink_cnt <= BLINK_W'(1);
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TIME_BLINK=4, TIME_OUT=50.
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode, key_inc, key_dec;
  logic [16:0] cur_time;
  logic        run_en, load, blink;
  logic [16:0] load_time;
  logic [1:0]  sel;

  int checks = 0;
  int failures = 0;
  int load_pulses = 0;
  int base;
  bit double_load = 1'b0;
  logic prev_load = 1'b0;

  clock_set_ctrl #(.TIME_BLINK(4), .TIME_OUT(50)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .key_dec   (key_dec),
    .cur_time  (cur_time),
    .run_en    (run_en),
    .load      (load),
    .load_time (load_time),
    .sel       (sel),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  // Count load pulses and flag any back-to-back load.
  always @(negedge clk) begin
    if (load) load_pulses++;
    if (load && prev_load) double_load = 1'b1;
    prev_load = load;
  end

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive keys for one rising edge; returns at posedge+1 with keys released.
  task automatic tick(input logic m, input logic i, input logic d);
    key_mode = m;
    key_inc  = i;
    key_dec  = d;
    @(posedge clk);
    #1;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
  endtask

  typedef struct {
    logic [16:0] cur;
    logic        m, i, d;
    logic [1:0]  sel;
    logic        run_en;
    logic        load;
    logic [16:0] lt;
    logic        blink;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // 12:34:56 -> mode, inc x3, mode, dec, mode, mode -> load 15:33:56
    vecs[0] = '{hms(12,34,56), 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 17'd0,          1'b1};
    vecs[1] = '{hms(12,34,56), 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 17'd0,          1'b1};
    vecs[2] = '{hms(12,34,56), 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 17'd0,          1'b1};
    vecs[3] = '{hms(12,34,56), 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 17'd0,          1'b1};
    vecs[4] = '{hms(12,34,56), 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 17'd0,          1'b1};
    vecs[5] = '{hms(12,34,56), 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 17'd0,          1'b1};
    vecs[6] = '{hms(12,34,56), 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 17'd0,          1'b1};
    vecs[7] = '{hms(12,34,56), 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, hms(15,33,56), 1'b1};
    vecs[8] = '{hms(12,34,56), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, hms(15,33,56), 1'b1};
    vecs[9] = '{hms(12,34,56), 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, hms(15,33,56), 1'b1};

    rst_n = 1'b0;
    key_mode = 1'b0;
    key_inc = 1'b0;
    key_dec = 1'b0;
    cur_time = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_run_en", run_en, 1);
    check("rst_load", load, 0);
    check("rst_load_time", load_time, 0);
    check("rst_sel", sel, 0);
    check("rst_blink", blink, 1);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      cur_time = vecs[k].cur;
      tick(vecs[k].m, vecs[k].i, vecs[k].d);
      check($sformatf("vec%0d_sel", k), sel, vecs[k].sel);
      check($sformatf("vec%0d_run_en", k), run_en, vecs[k].run_en);
      check($sformatf("vec%0d_load", k), load, vecs[k].load);
      check($sformatf("vec%0d_load_time", k), load_time, vecs[k].lt);
      check($sformatf("vec%0d_blink", k), blink, vecs[k].blink);
    end

    // Wrap at both ends: hour 23+1, minute 0-1, second 59+1.
    cur_time = hms(23,0,59);
    tick(1,0,0); tick(0,1,0);
    tick(1,0,0); tick(0,0,1);
    tick(1,0,0); tick(0,1,0);
    tick(1,0,0);
    check("wrap_load", load, 1);
    check("wrap_load_time", load_time, hms(0,59,0));
    tick(0,0,0);

    // Idle timeout in SET_H.
    tick(1,0,0);
    base = load_pulses;
    repeat (49) tick(0,0,0);
    check("to_before_sel", sel, 1);
    check("to_before_run_en", run_en, 0);
    tick(0,0,0);
    check("to_after_sel", sel, 0);
    check("to_after_run_en", run_en, 1);
    check("to_after_load", load, 0);
    tick(0,0,0);
    check("to_no_load", load_pulses, base);
    check("to_load_time_held", load_time, hms(0,59,0));

    // inc+dec together in SET_M is ignored.
    cur_time = hms(10,20,30);
    tick(1,0,0); tick(1,0,0);
    check("incdec_sel", sel, 2);
    tick(0,1,1);
    tick(1,0,0); tick(1,0,0);
    check("incdec_load_time", load_time, hms(10,20,30));
    tick(0,0,0);

    // mode+inc in SET_H: mode advances, inc dropped.
    cur_time = hms(5,6,7);
    tick(1,0,0);
    tick(1,1,0);
    check("modeinc_sel", sel, 2);
    tick(1,0,0); tick(1,0,0);
    check("modeinc_load", load, 1);
    check("modeinc_load_time", load_time, hms(5,6,7));
    tick(0,0,0);

    // One-cycle reset while in SET_S.
    cur_time = hms(1,2,3);
    tick(1,0,0); tick(1,0,0); tick(1,0,0);
    check("rstmid_pre_sel", sel, 3);
    base = load_pulses;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstmid_sel", sel, 0);
    check("rstmid_run_en", run_en, 1);
    check("rstmid_load", load, 0);
    check("rstmid_load_time", load_time, 0);
    check("rstmid_blink", blink, 1);
    repeat (3) tick(0,0,0);
    check("rstmid_no_load", load_pulses, base);

    // Out-of-range hour captured as 0; blink cadence and forcing on inc.
    cur_time = {5'd30, 6'd10, 6'd20};
    tick(1,0,0);
    check("blink_entry", blink, 1);
    for (int k = 1; k <= 12; k++) begin
      tick(0,0,0);
      check($sformatf("blink_idle%0d", k), blink, ((k / 4) % 2 == 0) ? 1 : 0);
    end
    tick(0,1,0);
    check("blink_after_inc", blink, 1);
    for (int k = 1; k <= 4; k++) begin
      tick(0,0,0);
      check($sformatf("blink_post_inc%0d", k), blink, (k < 4) ? 1 : 0);
    end
    tick(1,0,0); tick(1,0,0); tick(1,0,0);
    check("clamp_load_time", load_time, {5'd1, 6'd10, 6'd20});
    tick(0,0,0);

    check("total_load_pulses", load_pulses, 5);
    check("load_single_cycle", double_load, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
